instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Program-counter and fetch stage sitting directly upstream of rom_case, the combinational 256 x 64-bit instruction ROM.
- Drives the ROM address from an internal PC and registers the returned 64-bit word, together with its PC, for the decode stage.
- Supports stall, taken-branch redirect with a one-bubble flush, halt-opcode detection, and a retired-fetch counter.

Parameters:
- ADDR_W, 8, PC/ROM address width.
- DATA_W, 64, instruction word width.
- RESET_PC, 8'h00, PC value after reset.
- HALT_OPCODE, 8'hFF, value of instruction bits [DATA_W-1:DATA_W-8] that marks HALT.
- CNT_W, 16, fetch counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream not ready; hold all fetch state.
- branch_taken  in  1  redirect the PC this cycle.
- branch_target  in  ADDR_W  redirect address.
- rom_address  out  ADDR_W  address to rom_case; equals the current PC register, driven combinationally.
- rom_data  in  DATA_W  rom_case output; combinational, valid in the same cycle.
- instr  out  DATA_W  registered instruction word.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- halted  out  1  high while in HALTED state.
- fetch_count  out  CNT_W  number of words latched with instr_valid=1.

Behaviour:
- Reset, at any edge with reset=1 and regardless of state:
  - pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, state=FETCH.
- States: FETCH, HALTED.
- Per-edge priority, highest first: reset > branch_taken > stall > normal fetch.
- FETCH, normal (no stall, no branch):
  - instr<=rom_data, instr_pc<=pc, instr_valid<=1, fetch_count<=fetch_count+1.
  - pc<=pc+1 modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
  - Latency: the word at address A appears on instr one edge after rom_address=A.
  - Throughput: 1 word/cycle.
- FETCH, stall=1 with branch_taken=0: pc, instr, instr_pc, instr_valid and fetch_count all hold.
- branch_taken=1, in either state and regardless of stall:
  - pc<=branch_target, instr_valid<=0 (flushes the wrong-path word), state<=FETCH, halted<=0.
  - instr and instr_pc hold; fetch_count holds.
  - The first target word appears one edge later: exactly one bubble.
- Halt detection: in a FETCH normal cycle where rom_data[DATA_W-1:DATA_W-8]==HALT_OPCODE:
  - The HALT word is latched as a normal fetch (instr_valid=1, counted).
  - pc<=pc+1 as usual.
  - state<=HALTED, halted<=1 on that same edge.
- HALTED:
  - pc, instr, instr_pc and fetch_count hold; instr_valid<=0 on the first HALTED edge and stays 0.
  - stall is ignored.
  - Exit only via reset or branch_taken.
- Halt opcode under stall: a halt opcode on rom_data while stall=1 is not acted on until the stall clears.
- fetch_count wraps modulo 2^CNT_W.
- Reset mid-stall or mid-halt behaves identically to reset from any other state.
- Implementation: no combinational path from stall or branch_taken to rom_address; rom_address is the PC register only.

Test Plan:
- Reset, then 4 free-running cycles, ROM[n]=64'h0000_0000_0000_00nn:
  - Required: instr sequence 00,01,02,03 on successive edges; instr_pc=0..3; instr_valid=1 from the first edge after reset; fetch_count=4.
- Stall for 3 cycles after instr_pc=2:
  - Required: instr_pc stays 2, rom_address stays 3, fetch_count unchanged.
  - On release, the next instr_pc is 3.
- branch_taken=1, branch_target=8'h40, at pc=5:
  - Required: next edge instr_valid=0 and instr_pc unchanged.
  - Following edge: instr_pc=8'h40, instr=ROM[40].
- branch_taken and stall both asserted in the same cycle:
  - Required: the redirect wins; pc=target on the next edge.
- ROM[8'h06]=64'hFF00_0000_0000_0000:
  - Required: instr_pc=6 latched with instr_valid=1 and halted=1 on the same edge; instr_valid=0 from the next edge; pc stays 7 for 10 cycles.
  - Then branch_taken to 8'h00: halted=0 and fetch resumes at 0.
- Branch to 8'hFE and run 3 cycles:
  - Required: instr_pc=FE, FF, 00 (wrap-around).
  - Assert reset mid-sequence: all outputs return to reset values on that edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter and fetch stage in front of the combinational
// instruction ROM (rom_case). The ROM address comes straight from the PC register. The
// returned word is registered together with its PC for the decode stage.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   stall         in   downstream not ready; hold all fetch state
//   branch_taken  in   redirect the PC this cycle (wins over stall, exits HALTED)
//   branch_target in   redirect address
//   rom_address   out  address to the ROM (the PC register only)
//   rom_data      in   ROM word for rom_address, valid in the same cycle
//   instr         out  registered instruction word
//   instr_pc      out  PC of instr
//   instr_valid   out  instr/instr_pc hold a valid instruction
//   halted        out  high while in the HALTED state
//   fetch_count   out  number of words latched with instr_valid=1 (wraps)
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          DATA_W      = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC    = 8'h00,
    parameter logic [7:0]           HALT_OPCODE = 8'hFF,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [0:0] {StFetch, StHalted} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                is_halt_word;
    logic                fetch_now;

    assign is_halt_word = (rom_data[DATA_W-1 -: 8] == HALT_OPCODE);
    // A word is accepted only in FETCH with no redirect and no stall.
    assign fetch_now    = (state_q == StFetch) && !branch_taken && !stall;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (branch_taken) begin
                    state_d = StFetch;
                end else if (fetch_now && is_halt_word) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                // Stall is ignored here; only a redirect (or reset) leaves.
                if (branch_taken) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Datapath next-state
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (branch_taken) begin
            // Flush the wrong-path word; instr/instr_pc keep their last values.
            pc_d    = branch_target;
            valid_d = 1'b0;
        end else if (state_q == StHalted) begin
            valid_d = 1'b0;
        end else if (fetch_now) begin
            instr_d    = rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            count_d    = count_q + CNT_W'(1);
            pc_d       = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    // Outputs
    always_comb begin
        rom_address = pc_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        instr_valid = valid_q;
        fetch_count = count_q;
        halted      = (state_q == StHalted);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [7:0]  rom_address;
    logic [63:0] rom_data;
    logic [63:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [63:0] rom [256];
    assign rom_data = rom[rom_address];

    int nchecks = 0;
    int nerrors = 0;

    // Reference model state, advanced from the behavioural rules each edge.
    logic [7:0]  m_pc;
    logic [63:0] m_instr;
    logic [7:0]  m_ipc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_count;

    instr_fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, advance the model, and move to 1 time unit past the edge.
    task automatic step(input logic rst, input logic st, input logic br, input logic [7:0] tgt);
        logic [63:0] w;
        reset         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        if (rst) begin
            m_pc = 8'h00; m_instr = '0; m_ipc = 8'h00;
            m_valid = 1'b0; m_halted = 1'b0; m_count = '0;
        end else if (br) begin
            m_pc = tgt; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (!st) begin
            w       = rom[m_pc];
            m_instr = w;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 16'd1;
            m_pc    = m_pc + 8'd1;
            if (w[63:56] == 8'hFF) m_halted = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic load_plain_rom();
        for (int i = 0; i < 256; i++) rom[i] = 64'(i);
        rom[8'h06] = 64'hFF00_0000_0000_0000;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        nchecks++;
        if ({instr, instr_pc, instr_valid, halted, fetch_count, rom_address} !== 98'd0) begin
            nerrors++;
            $display("FAIL reset: got instr=%h pc=%h v=%b h=%b cnt=%h addr=%h, want all zero",
                     instr, instr_pc, instr_valid, halted, fetch_count, rom_address);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] ii;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            ii = 8'(i);
            step(1'b0, 1'b0, 1'b0, 8'h00);
            nchecks++;
            if (instr !== 64'(ii) || instr_pc !== ii || instr_valid !== 1'b1) begin
                nerrors++;
                $display("FAIL seq[%0d]: got instr=%h pc=%h v=%b, want instr=%h pc=%h v=1",
                         i, instr, instr_pc, instr_valid, 64'(ii), ii);
            end
        end
        nchecks++;
        if (fetch_count !== 16'd4) begin
            nerrors++;
            $display("FAIL seq_count: got %0d, want 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            nchecks++;
            if (instr_pc !== 8'h02 || rom_address !== 8'h03 || fetch_count !== 16'd3 ||
                instr_valid !== 1'b1) begin
                nerrors++;
                $display("FAIL stall[%0d]: got pc=%h addr=%h cnt=%0d v=%b, want 02 03 3 1",
                         i, instr_pc, rom_address, fetch_count, instr_valid);
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        nchecks++;
        if (instr_pc !== 8'h03 || fetch_count !== 16'd4) begin
            nerrors++;
            $display("FAIL stall_release: got pc=%h cnt=%0d, want 03 4", instr_pc, fetch_count);
        end
    endtask

    task automatic test_branch();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h40);
        nchecks++;
        if (instr_valid !== 1'b0 || instr_pc !== 8'h04 || rom_address !== 8'h40 ||
            fetch_count !== 16'd5) begin
            nerrors++;
            $display("FAIL branch_bubble: got v=%b pc=%h addr=%h cnt=%0d, want 0 04 40 5",
                     instr_valid, instr_pc, rom_address, fetch_count);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        nchecks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || instr !== 64'h40) begin
            nerrors++;
            $display("FAIL branch_target: got v=%b pc=%h instr=%h, want 1 40 %h",
                     instr_valid, instr_pc, instr, 64'h40);
        end
    endtask

    task automatic test_branch_stall();
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h20;
        #1;
        nchecks++;
        if (rom_address !== 8'h41) begin
            nerrors++;
            $display("FAIL addr_no_comb_path: got %h, want 41", rom_address);
        end
        step(1'b0, 1'b1, 1'b1, 8'h20);
        nchecks++;
        if (rom_address !== 8'h20 || instr_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL branch_over_stall: got addr=%h v=%b, want 20 0", rom_address, instr_valid);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        nchecks++;
        if (instr_pc !== 8'h20 || instr_valid !== 1'b1) begin
            nerrors++;
            $display("FAIL branch_stall_resume: got pc=%h v=%b, want 20 1", instr_pc, instr_valid);
        end
    endtask

    task automatic test_halt();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        nchecks++;
        if (instr_pc !== 8'h06 || instr_valid !== 1'b1 || halted !== 1'b1 ||
            instr !== 64'hFF00_0000_0000_0000 || rom_address !== 8'h07) begin
            nerrors++;
            $display("FAIL halt_latch: got pc=%h v=%b h=%b instr=%h addr=%h, want 06 1 1 ff00.. 07",
                     instr_pc, instr_valid, halted, instr, rom_address);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            nchecks++;
            if (instr_valid !== 1'b0 || halted !== 1'b1 || rom_address !== 8'h07 ||
                fetch_count !== 16'd7 || instr_pc !== 8'h06) begin
                nerrors++;
                $display("FAIL halt_hold[%0d]: got v=%b h=%b addr=%h cnt=%0d pc=%h, want 0 1 07 7 06",
                         i, instr_valid, halted, rom_address, fetch_count, instr_pc);
            end
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        nchecks++;
        if (halted !== 1'b0 || instr_valid !== 1'b0 || rom_address !== 8'h00) begin
            nerrors++;
            $display("FAIL halt_exit: got h=%b v=%b addr=%h, want 0 0 00",
                     halted, instr_valid, rom_address);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        nchecks++;
        if (instr_pc !== 8'h00 || instr_valid !== 1'b1 || halted !== 1'b0) begin
            nerrors++;
            $display("FAIL halt_resume: got pc=%h v=%b h=%b, want 00 1 0",
                     instr_pc, instr_valid, halted);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            nchecks++;
            if (instr_pc !== want[i] || instr_valid !== 1'b1) begin
                nerrors++;
                $display("FAIL wrap[%0d]: got pc=%h v=%b, want %h 1", i, instr_pc, instr_valid, want[i]);
            end
        end
        step(1'b1, 1'b1, 1'b0, 8'h00);
        nchecks++;
        if ({instr, instr_pc, instr_valid, halted, fetch_count, rom_address} !== 98'd0) begin
            nerrors++;
            $display("FAIL wrap_reset: got instr=%h pc=%h v=%b h=%b cnt=%h addr=%h, want all zero",
                     instr, instr_pc, instr_valid, halted, fetch_count, rom_address);
        end
    endtask

    task automatic test_random();
        logic rst, st, br;
        for (int i = 0; i < 256; i++) begin
            rom[i] = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) rom[i][63:56] = 8'hFF;
            else if (rom[i][63:56] == 8'hFF) rom[i][63:56] = 8'h7F;
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 7) == 0);
            step(rst, st, br, 8'($urandom));
            nchecks++;
            if ({instr, instr_pc, instr_valid, halted, fetch_count, rom_address} !==
                {m_instr, m_ipc, m_valid, m_halted, m_count, m_pc}) begin
                nerrors++;
                $display("FAIL random[%0d]: got instr=%h pc=%h v=%b h=%b cnt=%h addr=%h, want instr=%h pc=%h v=%b h=%b cnt=%h addr=%h",
                         i, instr, instr_pc, instr_valid, halted, fetch_count, rom_address,
                         m_instr, m_ipc, m_valid, m_halted, m_count, m_pc);
            end
        end
    endtask

    initial begin
        load_plain_rom();
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_halt();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
